// File: rtl/ps2_keyboard_if.sv
// PS/2 keyboard receiver bus: keyboard pins, CPU read strobe and the status/data word.
`timescale 1ns/1ps
interface ps2_keyboard_if;
    logic        ps2c;
    logic        ps2d;
    logic        ack;
    logic [15:0] dout;

    // The receiver samples the pins and the strobe, and drives the word.
    modport slave  (input ps2c, ps2d, ack, output dout);
    // The keyboard/CPU side drives the pins and the strobe, and reads the word.
    modport master (output ps2c, ps2d, ack, input dout);
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver. It deserialises device-to-host frames and drops
// break (key release) sequences. It holds the last make code with valid and
// overrun flags until the CPU acknowledges the read.
`timescale 1ns/1ps
module ps2_keyboard #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          reset,
    ps2_keyboard_if.slave bus
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]        r_ps2cSync;
    logic [1:0]        r_ps2dSync;
    logic [FILT_W-1:0] r_filtCnt;
    logic              r_filtClk;
    logic              r_strobe;
    state_t            r_state;
    logic [2:0]        r_bitCnt;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic [WD_W-1:0]   r_wdog;
    logic              r_break;
    logic              r_valid;
    logic              r_overrun;
    logic [7:0]        r_code;

    logic w_bit;
    logic w_goodFrame;
    logic w_publish;

    assign w_bit = r_ps2dSync[1];

    // A frame is good when the stop bit is 1 and the data and parity bits hold an odd number of ones.
    assign w_goodFrame = r_strobe && (r_state == STOP) && w_bit && (^{r_shift, r_parity});
    assign w_publish   = w_goodFrame && !r_break && (r_shift != 8'hF0) && (r_shift != 8'hE0);

    assign bus.dout = {r_valid, r_overrun, 6'b000000, r_code};

    // Two-flop synchronisers for both asynchronous keyboard pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ps2cSync <= 2'b11;
            r_ps2dSync <= 2'b11;
        end else begin
            r_ps2cSync <= {r_ps2cSync[0], bus.ps2c};
            r_ps2dSync <= {r_ps2dSync[0], bus.ps2d};
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN identical differing samples; its falling edge is the bit strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filtCnt <= '0;
            r_filtClk <= 1'b1;
            r_strobe  <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (r_ps2cSync[1] != r_filtClk) begin
                if (r_filtCnt == FILT_W'(FILTER_LEN - 1)) begin
                    r_filtCnt <= '0;
                    r_filtClk <= r_ps2cSync[1];
                    r_strobe  <= ~r_ps2cSync[1];
                end else begin
                    r_filtCnt <= r_filtCnt + FILT_W'(1);
                end
            end else begin
                r_filtCnt <= '0;
            end
        end
    end

    // Frame receiver with an idle watchdog, plus the break-flag tracking for completed good bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_bitCnt <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_wdog   <= '0;
            r_break  <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_wdog <= '0;
                if (r_strobe && !w_bit) begin
                    r_state  <= DATA;
                    r_bitCnt <= '0;
                end
            end else if (r_strobe) begin
                r_wdog <= '0;
                case (r_state)
                    DATA: begin
                        r_shift  <= {w_bit, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_parity <= w_bit;
                        r_state  <= STOP;
                    end
                    default: begin
                        r_state <= IDLE;
                        if (w_goodFrame) begin
                            if (r_shift == 8'hF0) begin
                                r_break <= 1'b1;
                            end else if (r_shift != 8'hE0) begin
                                r_break <= 1'b0;
                            end
                        end
                    end
                endcase
            end else if (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                r_wdog  <= '0;
                r_state <= IDLE;
            end else begin
                r_wdog <= r_wdog + WD_W'(1);
            end
        end
    end

    // Output word: a publish beats a simultaneous acknowledge; the acknowledge alone clears the flags but keeps the code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_code    <= '0;
        end else if (w_publish) begin
            r_code    <= r_shift;
            r_overrun <= r_valid && !bus.ack;
            r_valid   <= 1'b1;
        end else if (bus.ack) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for the PS/2 keyboard receiver: directed frames followed by random ones, compared with a byte-level model.
`timescale 1ns/1ps
module tb_ps2_keyboard;

    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 2000;
    localparam int HALF       = 200;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int passes = 0;

    bit         mValid;
    bit         mOverrun;
    bit         mBreak;
    logic [7:0] mCode;

    ps2_keyboard_if bus();

    ps2_keyboard #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] modelWord();
        return {mValid, mOverrun, 6'b000000, mCode};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mValid   = 1'b0;
        mOverrun = 1'b0;
        mBreak   = 1'b0;
        mCode    = 8'h00;
    endtask

    task automatic modelByte(input logic [7:0] b, input bit good, input bit ackSame);
        if (good) begin
            if (b == 8'hF0) begin
                mBreak = 1'b1;
            end else if (b == 8'hE0) begin
                mBreak = mBreak;
            end else if (mBreak) begin
                mBreak = 1'b0;
            end else begin
                mCode    = b;
                mOverrun = mValid && !ackSame;
                mValid   = 1'b1;
            end
        end
    endtask

    task automatic modelAck();
        mValid   = 1'b0;
        mOverrun = 1'b0;
    endtask

    task automatic sendBit(input bit v, input bit glitch);
        bus.ps2d = v;
        #HALF;
        bus.ps2c = 1'b0;
        if (glitch) begin
            #(HALF / 2);
            bus.ps2c = 1'b1;
            #20;
            bus.ps2c = 1'b0;
            #(HALF / 2 - 20);
        end else begin
            #HALF;
        end
        bus.ps2c = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit stopBit,
                                 input bit glitch, input int nBits);
        bit par;
        sendBit(1'b0, 1'b0);
        for (int i = 0; i < nBits; i++) begin
            sendBit(b[i], glitch && (i == 3));
        end
        if (nBits == 8) begin
            par = (~^b) ^ badPar;
            sendBit(par, 1'b0);
            sendBit(stopBit, 1'b0);
        end
        bus.ps2d = 1'b1;
        #HALF;
    endtask

    task automatic sendAndCheck(input string tag, input logic [7:0] b, input bit badPar,
                                input bit stopBit, input bit glitch);
        applyStimulus(b, badPar, stopBit, glitch, 8);
        modelByte(b, !badPar && stopBit, 1'b0);
        @(negedge clk);
        checkOutput(tag, bus.dout, modelWord());
    endtask

    task automatic pulseAck(input string tag);
        @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        modelAck();
        @(negedge clk);
        checkOutput(tag, bus.dout, modelWord());
    endtask

    // Directed scenarios first, then random frames with random errors, glitches and acknowledges.
    initial begin
        logic [7:0] b;
        int         pick;
        int         err;
        int         n;

        bus.ps2c = 1'b1;
        bus.ps2d = 1'b1;
        bus.ack  = 1'b0;
        modelReset();
        repeat (5) @(negedge clk);
        checkOutput("resetWord", bus.dout, 16'h0000);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        sendAndCheck("make1C", 8'h1C, 1'b0, 1'b1, 1'b0);
        pulseAck("ackMake");

        sendAndCheck("breakF0", 8'hF0, 1'b0, 1'b1, 1'b0);
        sendAndCheck("break1C", 8'h1C, 1'b0, 1'b1, 1'b0);
        sendAndCheck("make32", 8'h32, 1'b0, 1'b1, 1'b0);
        pulseAck("ack32");

        sendAndCheck("extE0", 8'hE0, 1'b0, 1'b1, 1'b0);
        sendAndCheck("badParity", 8'h1C, 1'b1, 1'b1, 1'b0);
        sendAndCheck("badStop", 8'h1C, 1'b0, 1'b0, 1'b0);
        sendAndCheck("glitch1C", 8'h1C, 1'b0, 1'b1, 1'b1);

        sendAndCheck("ovr1C", 8'h1C, 1'b0, 1'b1, 1'b0);
        sendAndCheck("ovr32", 8'h32, 1'b0, 1'b1, 1'b0);
        pulseAck("ackOvr");

        sendAndCheck("preSame", 8'h1C, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus.ack = 1'b1;
        modelAck();
        fork
            applyStimulus(8'h32, 1'b0, 1'b1, 1'b0, 8);
            begin
                n = 0;
                @(negedge clk);
                while (!bus.dout[15] && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                bus.ack = 1'b0;
                modelByte(8'h32, 1'b1, 1'b1);
                checkOutput("ackSame", bus.dout, modelWord());
            end
        join
        @(negedge clk);
        checkOutput("afterSame", bus.dout, modelWord());
        pulseAck("ackSameClear");

        applyStimulus(8'h55, 1'b0, 1'b1, 1'b0, 5);
        repeat (TIMEOUT + 500) @(negedge clk);
        sendAndCheck("afterTimeout", 8'h1C, 1'b0, 1'b1, 1'b0);

        applyStimulus(8'hAA, 1'b0, 1'b1, 1'b0, 3);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("asyncReset", bus.dout, modelWord());
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        sendAndCheck("afterReset", 8'h32, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0) begin
                b = 8'hF0;
            end else if (pick == 1) begin
                b = 8'hE0;
            end else begin
                b = 8'($urandom_range(0, 255));
            end
            err = $urandom_range(0, 7);
            sendAndCheck("random", b, err == 0, err != 1, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                pulseAck("randomAck");
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
